sync_memory: RTL and testbench

- Clocked, parametrised successor to the team's 8-bit 256-entry memory.
- Data width and address width are configurable, and the read-during-write mode is selectable.
- A registered out/valid pair replaces the level-sensitive access.
- A built-in clear engine zeroes the array after reset or on request. It sits between the CPU datapath and its storage, and serves as data RAM or as register-file backing.

---
 rtl/sync_memory.sv | 92 +++++++++
 tb/tb_sync_memory.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_memory.sv
// Parametrised single-port synchronous memory with registered out/valid and a
// sequential clear engine that zeroes (or presets) the array after reset or on request.
module sync_memory #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      ADDR_WIDTH  = 8,
   parameter int unsigned      READ_MODE   = 0,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [WIDTH-1:0]      in,
   input  logic                  write,
   input  logic                  enable,
   output logic                  ready,
   output logic [WIDTH-1:0]      out,
   output logic                  valid
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  clr_last;
   logic                  accept;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [WIDTH-1:0]      mem_wdata;
   logic [WIDTH-1:0]      rd_word;

   assign ready    = (state == ST_IDLE);
   assign accept   = enable & ready;
   assign clr_last = &clr_cnt;
   assign rd_word  = mem[address];

   // The clear engine owns the single write port whenever it is running.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = address;
      mem_wdata = in;
      if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt;
         mem_wdata = CLEAR_VALUE;
      end else if (accept && write) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         // Terminal count leaves CLEAR; clear requests here are ignored.
         if (clr_last) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
         end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
         end
      end else if (clear) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out   <= '0;
         valid <= 1'b0;
      end else begin
         valid <= accept;
         if (accept) begin
            out <= (write && (READ_MODE == 0)) ? in : rd_word;
         end
      end
   end

endmodule

// File: tb/tb_sync_memory.sv
// Randomized self-checking bench for sync_memory: two configurations checked
// against an array-based reference model of the memory contents and clear timing.
module tb_sync_memory;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 0: defaults (8-bit, 256 words, write-first, clear to 0)
   logic       rst0, clr0, wr0, en0, rdy0, val0;
   logic [7:0] addr0, in0, out0;
   // DUT 1: 16-bit, 16 words, read-first, clear to 0x3C
   logic        rst1, clr1, wr1, en1, rdy1, val1;
   logic [3:0]  addr1;
   logic [15:0] in1, out1;

   sync_memory u_dut0 (
      .clk(clk), .reset_n(rst0), .clear(clr0), .address(addr0), .in(in0),
      .write(wr0), .enable(en0), .ready(rdy0), .out(out0), .valid(val0)
   );

   sync_memory #(
      .WIDTH(16), .ADDR_WIDTH(4), .READ_MODE(1), .CLEAR_VALUE(16'h003C)
   ) u_dut1 (
      .clk(clk), .reset_n(rst1), .clear(clr1), .address(addr1), .in(in1),
      .write(wr1), .enable(en1), .ready(rdy1), .out(out1), .valid(val1)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [15:0] m0 [256];
   logic [15:0] m1 [16];
   logic [15:0] last0, last1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int unsigned depth(input int d);
      return (d == 0) ? 256 : 16;
   endfunction
   function automatic logic [15:0] cval(input int d);
      return (d == 0) ? 16'h0000 : 16'h003C;
   endfunction
   function automatic logic [15:0] dmask(input int d);
      return (d == 0) ? 16'h00FF : 16'hFFFF;
   endfunction
   function automatic logic [15:0] get_out(input int d);
      return (d == 0) ? {8'h00, out0} : out1;
   endfunction
   function automatic logic get_valid(input int d);
      return (d == 0) ? val0 : val1;
   endfunction
   function automatic logic get_ready(input int d);
      return (d == 0) ? rdy0 : rdy1;
   endfunction

   task automatic drive(input int d, input bit e, input bit w, input int unsigned a,
                        input logic [15:0] data, input bit c);
      if (d == 0) begin
         en0 = e; wr0 = w; addr0 = a[7:0]; in0 = data[7:0]; clr0 = c;
      end else begin
         en1 = e; wr1 = w; addr1 = a[3:0]; in1 = data; clr1 = c;
      end
   endtask

   // One accepted access; expectations come from the model array and the mode rules.
   task automatic access(input int d, input bit w, input int unsigned a,
                         input logic [15:0] data, input bit c, input string tag);
      logic [15:0] old, exp, wd;
      int unsigned ai;
      ai = a % depth(d);
      wd = data & dmask(d);
      drive(d, 1'b1, w, ai, wd, c);
      @(posedge clk); #1;
      old = (d == 0) ? m0[ai] : m1[ai];
      exp = (w && d == 0) ? wd : old;   // DUT 0 is write-first, DUT 1 read-first
      if (w) begin
         if (d == 0) m0[ai] = wd; else m1[ai] = wd;
      end
      check({tag, "_valid"}, 32'(get_valid(d)), 32'd1);
      check({tag, "_out"}, 32'(get_out(d)), 32'(exp));
      if (d == 0) last0 = exp; else last1 = exp;
      drive(d, 1'b0, 1'b0, 0, 16'h0, 1'b0);
   endtask

   task automatic idle(input int d);
      drive(d, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      @(posedge clk); #1;
      check("idle_valid", 32'(get_valid(d)), 32'd0);
      check("idle_hold", 32'(get_out(d)), 32'((d == 0) ? last0 : last1));
   endtask

   task automatic fill_model(input int d);
      for (int unsigned i = 0; i < depth(d); i++) begin
         if (d == 0) m0[i] = cval(d); else m1[i] = cval(d);
      end
   endtask

   // Counts clock edges until ready rises; optionally hammers a write while not ready.
   task automatic wait_clear(input int d, input int unsigned exp_n, input bit drop);
      int unsigned n;
      bit saw_valid;
      n = 0;
      saw_valid = 0;
      if (drop) drive(d, 1'b1, 1'b1, 32'h20, 16'h0055, 1'b0);
      while (!get_ready(d) && n < exp_n + 20) begin
         @(posedge clk); #1;
         n++;
         if (get_valid(d)) saw_valid = 1;
      end
      drive(d, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      check("clear_len", n, exp_n);
      check("clear_no_valid", 32'(saw_valid), 32'd0);
      check("clear_out_hold", 32'(get_out(d)), 32'((d == 0) ? last0 : last1));
      fill_model(d);
   endtask

   task automatic do_reset(input int d);
      if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
      #2;
      check("rst_ready", 32'(get_ready(d)), 32'd0);
      check("rst_valid", 32'(get_valid(d)), 32'd0);
      check("rst_out", 32'(get_out(d)), 32'd0);
      if (d == 0) last0 = '0; else last1 = '0;
      @(posedge clk); #1;
      if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
   endtask

   task automatic pulse_clear(input int d);
      drive(d, 1'b0, 1'b0, 0, 16'h0, 1'b1);
      @(posedge clk); #1;
      drive(d, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      check("pulse_valid", 32'(get_valid(d)), 32'd0);
      check("pulse_ready", 32'(get_ready(d)), 32'd0);
   endtask

   task automatic random_ops(input int d, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) idle(d);
         else access(d, 1'($urandom_range(0, 1)), $urandom_range(0, depth(d) - 1),
                     16'($urandom), 1'b0, "rnd");
      end
   endtask

   task automatic fill_clear_verify(input int d);
      for (int unsigned a = 0; a < depth(d); a++) access(d, 1'b1, a, 16'(a), 1'b0, "fill");
      pulse_clear(d);
      wait_clear(d, depth(d), 1'b0);
      for (int unsigned a = 0; a < depth(d); a++) access(d, 1'b0, a, 16'h0, 1'b0, "post_clr");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst0 = 1'b0; rst1 = 1'b0;
      drive(0, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      drive(1, 1'b0, 1'b0, 0, 16'h0, 1'b0);
      #12;

      // ---- DUT 0 ----
      do_reset(0);
      wait_clear(0, 256, 1'b0);
      access(0, 1'b0, 32'h00, 16'h0, 1'b0, "rd00");
      access(0, 1'b0, 32'h7F, 16'h0, 1'b0, "rd7f");
      access(0, 1'b0, 32'hFF, 16'h0, 1'b0, "rdff");
      access(0, 1'b1, 32'h10, 16'h00A5, 1'b0, "wr10");
      access(0, 1'b0, 32'h10, 16'h0, 1'b0, "rd10");
      idle(0);
      fill_clear_verify(0);

      pulse_clear(0);
      wait_clear(0, 256, 1'b1);
      access(0, 1'b0, 32'h20, 16'h0, 1'b0, "drop20");

      access(0, 1'b1, 32'h05, 16'h0099, 1'b1, "clrwr");
      check("clrwr_ready", 32'(rdy0), 32'd0);
      wait_clear(0, 256, 1'b0);
      access(0, 1'b0, 32'h05, 16'h0, 1'b0, "rd05");

      random_ops(0, 300);

      do_reset(0);
      repeat (100) begin @(posedge clk); #1; end
      do_reset(0);
      wait_clear(0, 256, 1'b0);
      access(0, 1'b0, 32'h63, 16'h0, 1'b0, "mid_rd");

      // ---- DUT 1 ----
      do_reset(1);
      wait_clear(1, 16, 1'b0);
      access(1, 1'b0, 32'h0, 16'h0, 1'b0, "b_rd0");
      access(1, 1'b0, 32'hF, 16'h0, 1'b0, "b_rdf");
      access(1, 1'b1, 32'h3, 16'hBEEF, 1'b0, "b_wr3");
      access(1, 1'b0, 32'h3, 16'h0, 1'b0, "b_rd3");
      random_ops(1, 150);
      do_reset(1);
      repeat (10) begin @(posedge clk); #1; end
      do_reset(1);
      wait_clear(1, 16, 1'b0);
      fill_clear_verify(1);
      access(1, 1'b1, 32'h9, 16'hBEEF, 1'b0, "b_wr9");
      access(1, 1'b0, 32'h9, 16'h0, 1'b0, "b_rd9");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
